// File: rtl/sync_fifo_pkg.sv
// Shared helpers and defaults for the parametrised single-clock FIFO.
package sync_fifo_pkg;

  localparam int DEF_DEPTH     = 16;
  localparam int DEF_AE_THRESH = 2;
  localparam int DEF_AF_MARGIN = 2;

  typedef enum logic {
    RD_STD  = 1'b0,
    RD_FWFT = 1'b1
  } rd_mode_e;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_param_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with thresholds, optional FWFT read and
// sticky overflow/underflow flags. rst is synchronous, active-low.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - DEF_AF_MARGIN,
  parameter int AE_THRESH = DEF_AE_THRESH,
  parameter int FWFT      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      clr_err
);

  localparam int       PW   = ptr_w(DEPTH);
  localparam int       CW   = PW + 1;
  localparam rd_mode_e MODE = (FWFT != 0) ? RD_FWFT : RD_STD;

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AE_THRESH < 0 ||
      AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH) begin : g_bad_params
    $fatal(1, "sync_fifo_param: need pow2 DEPTH>=2 and 0<=AE_THRESH<AF_THRESH<=DEPTH");
  end

  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d, ram_rdata;
  logic              rd_valid_q, rd_valid_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              rd_acc, wr_acc;

  assign full         = (count_q == FULL_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;

  // A pop frees a slot in the same cycle, so a write into a full FIFO
  // still proceeds when a read is accepted alongside it.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(PW)) u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wptr_q),
    .wdata_i (wr_data),
    .raddr_i (rptr_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    wptr_d     = wr_acc ? wptr_q + PW'(1) : wptr_q;
    rptr_d     = rd_acc ? rptr_q + PW'(1) : rptr_q;
    count_d    = count_q + CW'(wr_acc) - CW'(rd_acc);
    rd_data_d  = rd_acc ? ram_rdata : rd_data_q;
    rd_valid_d = rd_acc;
    // A new error in the same cycle beats clr_err.
    ovf_d      = (wr_en && !wr_acc) ? 1'b1 : (clr_err ? 1'b0 : ovf_q);
    unf_d      = (rd_en && !rd_acc) ? 1'b1 : (clr_err ? 1'b0 : unf_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign rd_data   = (MODE == RD_FWFT) ? ram_rdata : rd_data_q;
  assign rd_valid  = (MODE == RD_FWFT) ? !empty : rd_valid_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: one standard-mode and one FWFT instance checked
// against a queue model every cycle, plus directed literal expectations.
module tb_sync_fifo_param;

  localparam int W = 32;
  localparam int D = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // standard-mode instance (0) and FWFT instance (1)
  logic         wr_en0 = 0, rd_en0 = 0, clr0 = 0;
  logic [W-1:0] wr_data0 = '0, rd_data0;
  logic         rd_valid0, full0, empty0, af0, ae0, ovf0, unf0;
  logic [4:0]   count0;

  logic         wr_en1 = 0, rd_en1 = 0, clr1 = 0;
  logic [W-1:0] wr_data1 = '0, rd_data1;
  logic         rd_valid1, full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0]   count1;

  sync_fifo_param #(.DATA_W(W), .DEPTH(D), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .wr_data(wr_data0), .rd_en(rd_en0),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0), .overflow(ovf0),
    .underflow(unf0), .clr_err(clr0)
  );

  sync_fifo_param #(.DATA_W(W), .DEPTH(D), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_data(wr_data1), .rd_en(rd_en1),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1), .overflow(ovf1),
    .underflow(unf1), .clr_err(clr1)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: a queue of stored words plus sticky flags
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] m_rdd0 = '0;
  logic         m_rdv0 = 0, m_ovf0 = 0, m_unf0 = 0, m_ovf1 = 0, m_unf1 = 0;
  bit           started = 0;

  always @(posedge clk) begin
    bit r, w;
    if (!rst) begin
      exp_q0.delete(); exp_q1.delete();
      m_rdd0 = '0; m_rdv0 = 0;
      m_ovf0 = 0; m_unf0 = 0; m_ovf1 = 0; m_unf1 = 0;
      started = 1;
    end else begin
      r = rd_en0 && exp_q0.size() != 0;
      w = wr_en0 && (exp_q0.size() < D || r);
      if (r) m_rdd0 = exp_q0.pop_front();
      m_rdv0 = r;
      if (w) exp_q0.push_back(wr_data0);
      m_ovf0 = (wr_en0 && !w) ? 1'b1 : (clr0 ? 1'b0 : m_ovf0);
      m_unf0 = (rd_en0 && !r) ? 1'b1 : (clr0 ? 1'b0 : m_unf0);

      r = rd_en1 && exp_q1.size() != 0;
      w = wr_en1 && (exp_q1.size() < D || r);
      if (r) void'(exp_q1.pop_front());
      if (w) exp_q1.push_back(wr_data1);
      m_ovf1 = (wr_en1 && !w) ? 1'b1 : (clr1 ? 1'b0 : m_ovf1);
      m_unf1 = (rd_en1 && !r) ? 1'b1 : (clr1 ? 1'b0 : m_unf1);
    end
  end

  // compare process, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      chk("std_count", count0, exp_q0.size());
      chk("std_full", full0, exp_q0.size() == D);
      chk("std_empty", empty0, exp_q0.size() == 0);
      chk("std_af", af0, exp_q0.size() >= 14);
      chk("std_ae", ae0, exp_q0.size() <= 2);
      chk("std_ovf", ovf0, m_ovf0);
      chk("std_unf", unf0, m_unf0);
      chk("std_rdv", rd_valid0, m_rdv0);
      chk("std_rdd", rd_data0, m_rdd0);

      chk("fw_count", count1, exp_q1.size());
      chk("fw_full", full1, exp_q1.size() == D);
      chk("fw_empty", empty1, exp_q1.size() == 0);
      chk("fw_ovf", ovf1, m_ovf1);
      chk("fw_unf", unf1, m_unf1);
      chk("fw_rdv", rd_valid1, exp_q1.size() != 0);
      if (exp_q1.size() != 0) chk("fw_rdd", rd_data1, exp_q1[0]);
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [W-1:0] d);
    wr_en0 = 1; wr_data0 = d; cyc(); wr_en0 = 0;
  endtask

  task automatic pop0_expect(input string name, input logic [W-1:0] d);
    rd_en0 = 1; cyc(); rd_en0 = 0;
    chk(name, rd_data0, d);
    chk({name, "_v"}, rd_valid0, 1'b1);
  endtask

  initial begin
    rst = 0;
    cyc(); cyc();
    rst = 1;
    chk("rst_count", count0, 5'd0);
    chk("rst_empty", empty0, 1'b1);
    chk("rst_ae", ae0, 1'b1);
    chk("rst_rdd", rd_data0, 32'h0);

    // fill with A0..AF
    for (int i = 0; i < 16; i++) begin
      push0(32'hA0 + i);
      chk("fill_ae", ae0, (i + 1) <= 2);
      chk("fill_af", af0, (i + 1) >= 14);
    end
    chk("full_flag", full0, 1'b1);
    chk("full_count", count0, 5'd16);
    push0(32'hB0);
    chk("ovf_set", ovf0, 1'b1);
    chk("ovf_count", count0, 5'd16);

    // drain in order, one cycle after each rd_en
    for (int i = 0; i < 16; i++) pop0_expect("drain", 32'hA0 + i);
    chk("drain_empty", empty0, 1'b1);
    rd_en0 = 1; cyc(); rd_en0 = 0;
    chk("unf_set", unf0, 1'b1);
    chk("unf_hold", rd_data0, 32'hAF);
    chk("unf_rdv", rd_valid0, 1'b0);
    clr0 = 1; cyc(); clr0 = 0;
    chk("clr_ovf", ovf0, 1'b0);

    // pointer wrap
    for (int i = 0; i < 10; i++) push0(32'hC0 + i);
    for (int i = 0; i < 10; i++) pop0_expect("wrap1", 32'hC0 + i);
    for (int i = 0; i < 12; i++) push0(32'hD0 + i);
    for (int i = 0; i < 12; i++) pop0_expect("wrap2", 32'hD0 + i);
    chk("wrap_count", count0, 5'd0);

    // full with simultaneous write and read
    for (int i = 0; i < 16; i++) push0(32'hE0 + i);
    wr_en0 = 1; rd_en0 = 1; wr_data0 = 32'hEE; cyc(); wr_en0 = 0; rd_en0 = 0;
    chk("sim_rdd", rd_data0, 32'hE0);
    chk("sim_count", count0, 5'd16);
    chk("sim_ovf", ovf0, 1'b0);
    push0(32'hEF);
    chk("ovf2", ovf0, 1'b1);
    for (int i = 0; i < 9; i++) pop0_expect("part", 32'hE1 + i);
    chk("mid_count", count0, 5'd7);

    // reset mid-stream with activity on the inputs
    wr_en0 = 1; rd_en0 = 1; wr_data0 = 32'h99; rst = 0; cyc();
    rst = 1; wr_en0 = 0; rd_en0 = 0;
    chk("mrst_count", count0, 5'd0);
    chk("mrst_empty", empty0, 1'b1);
    chk("mrst_ovf", ovf0, 1'b0);
    chk("mrst_rdv", rd_valid0, 1'b0);

    // read+write on empty: write wins, read is an underflow
    wr_en0 = 1; rd_en0 = 1; wr_data0 = 32'h77; cyc(); wr_en0 = 0; rd_en0 = 0;
    chk("we_count", count0, 5'd1);
    chk("we_unf", unf0, 1'b1);
    chk("we_rdv", rd_valid0, 1'b0);
    for (int i = 0; i < 15; i++) push0(32'h100 + i);
    wr_en0 = 1; clr0 = 1; wr_data0 = 32'h1FF; cyc(); wr_en0 = 0; clr0 = 0;
    chk("clr_vs_set_ovf", ovf0, 1'b1);
    chk("clr_unf", unf0, 1'b0);
    for (int i = 0; i < 16; i++) begin rd_en0 = 1; cyc(); end
    rd_en0 = 0;

    // first-word-fall-through instance
    wr_en1 = 1; wr_data1 = 32'h55; cyc(); wr_en1 = 0;
    chk("fw_vis_v", rd_valid1, 1'b1);
    chk("fw_vis_d", rd_data1, 32'h55);
    rd_en1 = 1; cyc(); rd_en1 = 0;
    chk("fw_pop_empty", empty1, 1'b1);
    chk("fw_pop_v", rd_valid1, 1'b0);
    wr_en1 = 1;
    wr_data1 = 32'h11; cyc();
    wr_data1 = 32'h22; cyc();
    wr_data1 = 32'h33; cyc();
    wr_en1 = 0;
    chk("fw_head", rd_data1, 32'h11);
    rd_en1 = 1; cyc();
    chk("fw_next1", rd_data1, 32'h22);
    cyc();
    chk("fw_next2", rd_data1, 32'h33);
    cyc(); cyc();
    rd_en1 = 0;
    chk("fw_unf", unf1, 1'b1);
    wr_en1 = 1; rd_en1 = 1; wr_data1 = 32'h44; cyc(); wr_en1 = 0; rd_en1 = 0;
    chk("fw_we_d", rd_data1, 32'h44);
    chk("fw_we_count", count1, 5'd1);
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
